seg_display_arbiter: RTL and testbench

- Round-robin scheduler that shares the single 4-digit seven-segment display (driven by seg_display) among four requesters, e.g. ALU result, PC, register peek, debug word.
- Each requester raises a level request with a 16-bit value. The arbiter grants one owner at a time for a guaranteed dwell period and forwards that owner's value to seg_display's value input.
- Sits between the datapath/debug sources and seg_display, in the 100 MHz clk domain.

---
 rtl/seg_display_arbiter.sv | 148 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin owner selection for the shared 4-digit seven-segment display.
// One requester owns the display for a dwell period; its value is forwarded
// with one cycle of latency. All outputs are registered.
module seg_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    input  logic [15:0] val3,
    output logic [3:0]  grant,
    output logic [15:0] disp_value,
    output logic [1:0]  disp_src,
    output logic        disp_valid,
    output logic        dwell_done
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StShow} state_e;

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [15:0]      value_q, value_d;
    logic [1:0]       src_q, src_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [15:0]      vals [4];
    logic [1:0]       owner;
    logic [1:0]       search_start;
    logic [1:0]       winner;
    logic             take;

    // First requester at or after start, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    // Gather requester values for indexed selection.
    always_comb begin
        vals[0] = val0;
        vals[1] = val1;
        vals[2] = val2;
        vals[3] = val3;
    end

    // Next-state: idle grant, release, dwell expiry and direct handover.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        value_d      = value_q;
        src_d        = src_q;
        valid_d      = valid_q;
        done_d       = 1'b0;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        take         = 1'b0;
        owner        = src_q;
        // Idle searches from the pointer; a leaving owner hands on from k+1.
        search_start = (state_q == StIdle) ? ptr_q : owner + 2'd1;
        winner       = rr_pick(req, search_start);

        unique case (state_q)
            StIdle: begin
                if (|req) take = 1'b1;
            end
            StShow: begin
                if (!req[owner]) begin
                    // Release wins over expiry; no dwell_done here.
                    ptr_d = owner + 2'd1;
                    if (|req) begin
                        take = 1'b1;
                    end else begin
                        state_d = StIdle;
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    done_d = 1'b1;
                    if (|(req & ~(4'b0001 << owner))) begin
                        ptr_d = owner + 2'd1;
                        take  = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        value_d = vals[owner];
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    value_d = vals[owner];
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            state_d = StShow;
            grant_d = 4'b0001 << winner;
            src_d   = winner;
            value_d = vals[winner];
            valid_d = 1'b1;
            cnt_d   = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 4'b0000;
            value_q <= 16'h0000;
            src_q   <= 2'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            value_q <= value_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant      = grant_q;
    assign disp_value = value_q;
    assign disp_src   = src_q;
    assign disp_valid = valid_q;
    assign dwell_done = done_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a short dwell period.
module tb_seg_display_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] val0, val1, val2, val3;
    logic [3:0]  grant;
    logic [15:0] disp_value;
    logic [1:0]  disp_src;
    logic        disp_valid;
    logic        dwell_done;

    int tests = 0;
    int fails = 0;

    seg_display_arbiter #(.HOLD_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .val0       (val0),
        .val1       (val1),
        .val2       (val2),
        .val3       (val3),
        .grant      (grant),
        .disp_value (disp_value),
        .disp_src   (disp_src),
        .disp_valid (disp_valid),
        .dwell_done (dwell_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'h0);
        chk({tag, ".value"}, 32'(disp_value), 32'h0);
        chk({tag, ".src"},   32'(disp_src), 32'h0);
        chk({tag, ".valid"}, 32'(disp_valid), 32'h0);
        chk({tag, ".done"},  32'(dwell_done), 32'h0);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000;
        val0 = 16'h0; val1 = 16'h0; val2 = 16'h0; val3 = 16'h0;
        #1;
        step(1);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Idle with no requests for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("idle", {12'h0, grant, disp_valid, disp_value}, 32'h0);
        end

        // Single grant and live tracking of the owner's value.
        val2 = 16'hBEEF; req = 4'b0100;
        step(1);
        chk("grant2.grant", 32'(grant), 32'h4);
        chk("grant2.src", 32'(disp_src), 32'h2);
        chk("grant2.value", 32'(disp_value), 32'hBEEF);
        chk("grant2.valid", 32'(disp_valid), 32'h1);
        val2 = 16'h1234;
        step(1);
        chk("track2.value", 32'(disp_value), 32'h1234);
        req = 4'b0000;
        step(1);
        chk("rel2.grant", 32'(grant), 32'h0);
        chk("rel2.valid", 32'(disp_valid), 32'h0);
        chk("rel2.value", 32'(disp_value), 32'h1234);
        chk("rel2.src", 32'(disp_src), 32'h2);

        // All four requesting: 0,1,2,3,0 with 8 cycles each.
        rst = 1'b1; step(1); rst = 1'b0;
        val0 = 16'hA000; val1 = 16'hA001; val2 = 16'hA002; val3 = 16'hA003;
        req = 4'b1111;
        step(1);
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 8; c++) begin
                chk("rr.grant", 32'(grant), 32'(4'b0001 << o));
                chk("rr.done", 32'(dwell_done), (c == 0 && o != 0) ? 32'h1 : 32'h0);
                chk("rr.value", 32'(disp_value), 32'hA000 + 32'(o));
                step(1);
            end
        end
        chk("rr.wrap_grant", 32'(grant), 32'h1);
        chk("rr.wrap_done", 32'(dwell_done), 32'h1);

        // Sole requester 1 keeps ownership; dwell_done every 8 cycles.
        rst = 1'b1; step(1); rst = 1'b0;
        req = 4'b0010;
        step(1);
        for (int c = 0; c <= 30; c++) begin
            chk("sole.grant", 32'(grant), 32'h2);
            chk("sole.done", 32'(dwell_done), (c != 0 && c % 8 == 0) ? 32'h1 : 32'h0);
            step(1);
        end

        // Owner 0 releases at cycle 3 with 3 waiting: direct handover.
        rst = 1'b1; step(1); rst = 1'b0;
        val3 = 16'hC0DE;
        req = 4'b1001;
        step(1);
        chk("early.grant0", 32'(grant), 32'h1);
        step(2);
        req = 4'b1000;
        step(1);
        chk("early.grant3", 32'(grant), 32'h8);
        chk("early.done", 32'(dwell_done), 32'h0);
        chk("early.value", 32'(disp_value), 32'hC0DE);
        chk("early.src", 32'(disp_src), 32'h3);
        chk("early.valid", 32'(disp_valid), 32'h1);
        step(7);
        chk("early.cnt_restart", {grant, 3'b0, dwell_done}, 32'h80);
        step(1);
        chk("early.expiry", {grant, 3'b0, dwell_done}, 32'h81);
        req = 4'b0000;
        step(1);
        chk("idle3.grant", 32'(grant), 32'h0);
        chk("idle3.valid", 32'(disp_valid), 32'h0);
        chk("idle3.src", 32'(disp_src), 32'h3);
        val3 = 16'hFFFF;
        step(2);
        chk("idle3.hold", 32'(disp_value), 32'hC0DE);

        // Move pointer to 2, then reset mid-dwell of owner 2.
        val1 = 16'h1111; val2 = 16'h2222;
        req = 4'b0010;
        step(1);
        chk("pre.grant1", 32'(grant), 32'h2);
        req = 4'b0000;
        step(1);
        req = 4'b0100;
        step(1);
        chk("pre.grant2", 32'(grant), 32'h4);
        step(3);
        rst = 1'b1;
        step(1);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        val0 = 16'h0F0F;
        req = 4'b0101;
        step(1);
        chk("postrst.grant", 32'(grant), 32'h1);
        chk("postrst.value", 32'(disp_value), 32'h0F0F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
